// File: rtl/scan_sel_gen.sv
// Scan controller for a multiplexed 8-digit display. It steps a 3-bit digit
// select at a programmable rate and presents that digit's segment byte from a
// host-written buffer. Segments are blanked for a short window after every
// digit change so the previous digit does not ghost onto the next one.
module scan_sel_gen #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLANK_CYC = 4,
  parameter bit          SEL_POL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic [2:0]       i_last,
  input  logic             i_wr,
  input  logic [2:0]       i_waddr,
  input  logic [7:0]       i_wdata,
  output logic [2:0]       o_sel,
  output logic             o_opt,
  output logic [7:0]       o_seg,
  output logic             o_blank,
  output logic             o_frame
);

  localparam logic [7:0] LP_BLANK   = 8'(BLANK_CYC);
  localparam logic [7:0] LP_SEG_OFF = 8'hFF;

  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_sel;
  logic             r_frame;
  logic             r_en_q;
  logic [7:0]       r_blank_cnt;
  logic             r_blank;
  logic [7:0]       r_seg;
  logic [7:0]       r_buf [8];

  logic       w_tick;
  logic       w_wrap;
  logic       w_start;
  logic [2:0] w_sel_nxt;

  // Tick detection, next digit select and blank-window start condition.
  always_comb begin
    w_tick    = i_en && (r_cnt >= i_div);
    // >= so an i_last lowered below the current digit still wraps.
    w_wrap    = (r_sel >= i_last);
    w_sel_nxt = r_sel;
    if (w_tick) begin
      w_sel_nxt = w_wrap ? 3'd0 : r_sel + 3'd1;
    end
    // Re-enabling is treated like a digit change so the display comes up
    // through the same blanking window.
    w_start   = i_en && (w_tick || !r_en_q);
  end

  // Prescaler: counts while enabled, clears on tick or when disabled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Digit select, frame pulse and previous-enable tracking.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sel   <= 3'd0;
      r_frame <= 1'b0;
      r_en_q  <= 1'b0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_frame <= w_tick && w_wrap;
      r_en_q  <= i_en;
    end
  end

  // Segment buffer; reset has priority so a write during reset is discarded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_buf <= '{default: LP_SEG_OFF};
    end else if (i_wr) begin
      r_buf[i_waddr] <= i_wdata;
    end
  end

  // Blank window countdown and registered segment output.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_blank_cnt <= 8'd0;
      r_blank     <= 1'b1;
      r_seg       <= LP_SEG_OFF;
    end else if (!i_en) begin
      r_blank_cnt <= 8'd0;
      r_blank     <= 1'b1;
      r_seg       <= LP_SEG_OFF;
    end else if (w_start) begin
      r_blank_cnt <= LP_BLANK;
      if (LP_BLANK == 8'd0) begin
        r_blank <= 1'b0;
        r_seg   <= r_buf[w_sel_nxt];
      end else begin
        r_blank <= 1'b1;
        r_seg   <= LP_SEG_OFF;
      end
    end else if (r_blank_cnt != 8'd0) begin
      r_blank_cnt <= r_blank_cnt - 8'd1;
      if (r_blank_cnt == 8'd1) begin
        r_blank <= 1'b0;
        r_seg   <= r_buf[r_sel];
      end
    end else if (!r_blank) begin
      // Refresh every cycle so buffer writes reach the display.
      r_seg <= r_buf[r_sel];
    end
  end

  assign o_sel   = r_sel;
  assign o_opt   = SEL_POL;
  assign o_seg   = r_seg;
  assign o_blank = r_blank;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: two instances (no blanking, 4-cycle blanking) share
// one stimulus. A cycle-level model checks both on every cycle; directed
// literal checks pin the model's behaviour at known points.
module tb_scan_sel_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic [2:0]  last;
  logic        wr;
  logic [2:0]  waddr;
  logic [7:0]  wdata;

  logic [2:0] sel0, sel1;
  logic [7:0] seg0, seg1;
  logic       blank0, blank1, frame0, frame1, opt0, opt1;

  int n_tests = 0;
  int n_fail  = 0;

  scan_sel_gen #(.DIV_W(16), .BLANK_CYC(0), .SEL_POL(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div(div), .i_last(last),
    .i_wr(wr), .i_waddr(waddr), .i_wdata(wdata),
    .o_sel(sel0), .o_opt(opt0), .o_seg(seg0), .o_blank(blank0), .o_frame(frame0)
  );

  scan_sel_gen #(.DIV_W(16), .BLANK_CYC(4), .SEL_POL(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_div(div), .i_last(last),
    .i_wr(wr), .i_waddr(waddr), .i_wdata(wdata),
    .o_sel(sel1), .o_opt(opt1), .o_seg(seg1), .o_blank(blank1), .o_frame(frame1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  int         blank_len [2] = '{0, 4};
  logic [7:0] m_buf [8];
  logic [2:0] m_sel;
  int         m_cnt;
  logic       m_frame;
  bit         m_off;
  int         m_since;
  bit         m_valid = 1'b0;
  logic [7:0] e_seg [2];
  logic [7:0] e_alt [2];
  logic       e_blank [2];

  // Advance the model across one rising edge; results describe the next cycle.
  task automatic model_step();
    logic [7:0] pre [8];
    bit         tick;
    pre = m_buf;
    if (!rst_n) begin
      m_buf   = '{default: 8'hFF};
      m_sel   = 3'd0;
      m_cnt   = 0;
      m_frame = 1'b0;
      m_off   = 1'b1;
      m_since = 0;
      m_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        e_blank[k] = 1'b1;
        e_seg[k]   = 8'hFF;
        e_alt[k]   = 8'hFF;
      end
    end else begin
      if (wr) m_buf[waddr] = wdata;
      if (!en) begin
        m_cnt   = 0;
        m_frame = 1'b0;
        m_off   = 1'b1;
        for (int k = 0; k < 2; k++) begin
          e_blank[k] = 1'b1;
          e_seg[k]   = 8'hFF;
          e_alt[k]   = 8'hFF;
        end
      end else begin
        tick    = (m_cnt >= int'(div));
        m_frame = tick && (m_sel >= last);
        if (tick) m_sel = (m_sel >= last) ? 3'd0 : m_sel + 3'd1;
        m_cnt   = tick ? 0 : m_cnt + 1;
        if (tick || m_off) m_since = 0;
        else if (m_since < 100000) m_since++;
        m_off = 1'b0;
        for (int k = 0; k < 2; k++) begin
          e_blank[k] = (m_since < blank_len[k]);
          e_seg[k]   = e_blank[k] ? 8'hFF : pre[m_sel];
          // A same-cycle write to the shown digit may appear one cycle early.
          e_alt[k]   = e_blank[k] ? 8'hFF : m_buf[m_sel];
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic cmp_inst(input int k, input logic [2:0] s, input logic [7:0] g,
                          input logic b, input logic f, input logic o);
    n_tests++;
    if (s !== m_sel || (g !== e_seg[k] && g !== e_alt[k]) || b !== e_blank[k] ||
        f !== m_frame || o !== 1'(k)) begin
      n_fail++;
      $display("FAIL model_dut%0d t=%0t: got sel=%0d seg=%h blank=%b frame=%b opt=%b, want sel=%0d seg=%h blank=%b frame=%b opt=%b",
               k, $time, s, g, b, f, o, m_sel, e_seg[k], e_blank[k], m_frame, 1'(k));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      cmp_inst(0, sel0, seg0, blank0, frame0, opt0);
      cmp_inst(1, sel1, seg1, blank1, frame1, opt1);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s t=%0t: wait bound expired, want event within bound", name, $time);
  endtask

  // Wait for the displayed digit on the blanking instance to change.
  task automatic wait_change(input string name, output logic [2:0] s, output logic f);
    logic [2:0] p;
    bit         ok;
    p  = sel1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel1 !== p) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_fail(name);
    s = sel1;
    f = frame1;
  endtask

  task automatic wait_unblank(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (blank1 === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) note_fail(name);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] lit_buf [8];
  logic [2:0] s;
  logic       f;
  int         k;
  int         j;
  bit         seen_unblank;
  bit         ok;

  initial begin
    rst_n = 1'b0; en = 1'b0; div = 16'd3; last = 3'd7;
    wr = 1'b0; waddr = 3'd0; wdata = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel0), 32'd0);
    check("rst_seg", 32'(seg1), 32'hFF);
    check("rst_blank", 32'(blank0), 32'd1);
    check("rst_frame", 32'(frame1), 32'd0);
    check("opt0", 32'(opt0), 32'd0);
    check("opt1", 32'(opt1), 32'd1);
    rst_n = 1'b1;

    // Load digits 0..7 with 8'h00..8'h07 while disabled.
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; waddr = 3'(i); wdata = 8'(i); lit_buf[i] = 8'(i);
      @(negedge clk);
    end
    wr = 1'b0;
    @(negedge clk);
    check("dis_blank", 32'(blank0), 32'd1);

    // Test 1: i_div=3, full scan; 4-cycle blanking never clears (div+1 <= 4).
    en = 1'b1; div = 16'd3; last = 3'd7;
    seen_unblank = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (blank1 !== 1'b1) seen_unblank = 1'b1;
      if (i == 1) begin
        check("t1_first_seg", 32'(seg0), 32'h00);
        check("t1_first_blank", 32'(blank0), 32'd0);
      end
      if (i == 4) begin
        check("t1_sel_step", 32'(sel0), 32'd1);
        check("t1_seg_step", 32'(seg0), 32'h01);
      end
      if (i == 32) begin
        check("t1_wrap_sel", 32'(sel0), 32'd0);
        check("t1_wrap_frame", 32'(frame0), 32'd1);
      end
      if (i == 33) check("t1_frame_once", 32'(frame0), 32'd0);
    end
    check("t1_perm_blank", 32'(seen_unblank), 32'd0);

    // Test 2: i_div=9 -> 4 blank cycles then 6 cycles of data per digit.
    div = 16'd9;
    repeat (12) @(negedge clk);
    wait_change("t2_wait", s, f);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (blank1 !== 1'b1) break;
      k++;
      @(negedge clk);
    end
    check("t2_blank_len", 32'(k), 32'd4);
    check("t2_seg", 32'(seg1), 32'(lit_buf[s]));
    j = 0;
    for (int i = 0; i < 20; i++) begin
      if (blank1 !== 1'b0 || sel1 !== s) break;
      j++;
      @(negedge clk);
    end
    check("t2_show_len", 32'(j), 32'd6);

    // Test 3: lower i_last below the current digit.
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel1 === 3'd5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_fail("t3_wait5");
    last = 3'd2;
    wait_change("t3_w0", s, f);
    check("t3_wrap_sel", 32'(s), 32'd0);
    check("t3_wrap_frame", 32'(f), 32'd1);
    wait_change("t3_w1", s, f);
    check("t3_sel1", 32'(s), 32'd1);
    wait_change("t3_w2", s, f);
    check("t3_sel2", 32'(s), 32'd2);
    wait_change("t3_w3", s, f);
    check("t3_sel0", 32'(s), 32'd0);
    check("t3_frame", 32'(f), 32'd1);
    last = 3'd7;

    // Test 4: live write to the displayed digit, then to another digit.
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sel1 === 3'd3 && blank1 === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_fail("t4_wait3");
    wr = 1'b1; waddr = 3'd3; wdata = 8'hA5; lit_buf[3] = 8'hA5;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    check("t4_seg_new", 32'(seg1), 32'hA5);
    check("t4_seg_new0", 32'(seg0), 32'hA5);
    wr = 1'b1; waddr = 3'd6; wdata = 8'h5A; lit_buf[6] = 8'h5A;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    check("t4_seg_keep", 32'(seg1), 32'hA5);

    // Lowering i_div below the running count ticks on the next edge.
    wait_change("div_wait", s, f);
    wait_unblank("div_unblank");
    s = sel1;
    div = 16'd2;
    @(negedge clk);
    check("div_cut_tick", 32'(sel1), 32'((s == 3'd7) ? 3'd0 : s + 3'd1));
    div = 16'd9;

    // Test 5: disable mid-digit, then re-enable.
    wait_unblank("t5_unblank");
    s = sel1;
    en = 1'b0;
    @(negedge clk);
    check("t5_off_blank", 32'(blank1), 32'd1);
    check("t5_off_seg", 32'(seg0), 32'hFF);
    check("t5_off_sel", 32'(sel1), 32'(s));
    repeat (4) @(negedge clk);
    check("t5_frozen", 32'(sel0), 32'(s));
    check("t5_no_frame", 32'(frame0), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("t5_on_seg0", 32'(seg0), 32'(lit_buf[s]));
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (blank1 !== 1'b1) break;
      k++;
      @(negedge clk);
    end
    check("t5_on_blank_len", 32'(k), 32'd4);
    check("t5_on_seg1", 32'(seg1), 32'(lit_buf[s]));
    check("t5_on_sel", 32'(sel1), 32'(s));

    // Test 6: reset mid-blank with a write pending.
    wait_change("t6_wait", s, f);
    rst_n = 1'b0; wr = 1'b1; waddr = s; wdata = 8'h3C;
    @(negedge clk);
    check("t6_sel", 32'(sel1), 32'd0);
    check("t6_seg", 32'(seg1), 32'hFF);
    check("t6_blank", 32'(blank1), 32'd1);
    check("t6_frame", 32'(frame1), 32'd0);
    rst_n = 1'b1; wr = 1'b0; div = 16'd0; last = 3'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_buf_ff", 32'(seg0), 32'hFF);
    end
    check("t6_div0_perm_blank", 32'(blank1), 32'd1);
    check("t6_div0_show", 32'(blank0), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
Upstream scan controller for the 3-to-8 active-low digit decoder in the multiplexed 8-digit display path.
- Holds an 8-entry x 8-bit segment buffer, written by the host.
- Steps a 3-bit digit select at a programmable rate.
- Presents the matching segment byte, with a ghost-suppression blanking window at every digit change.
- o_sel and o_opt drive the decoder's select and polarity inputs; o_seg drives the segment lines.

Parameters:
DIV_W, 16, width of the prescaler divisor and counter.
BLANK_CYC, 4, clock cycles o_seg is forced blank after each digit change; 0 disables blanking; legal range 0..255.
SEL_POL, 0, constant value driven on o_opt: 0 = decoder outputs active-low, 1 = decoder outputs inverted.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst_n  in  1  synchronous reset, active-low.
i_en  in  1  scan enable.
i_div  in  DIV_W  prescaler terminal count; the digit period is i_div+1 cycles.
i_last  in  3  highest digit index scanned; the sequence is 0..i_last, then wraps.
i_wr  in  1  segment buffer write strobe.
i_waddr  in  3  segment buffer write address.
i_wdata  in  8  segment byte, active-low segments.
o_sel  out  3  digit select to the decoder.
o_opt  out  1  decoder polarity, tied to SEL_POL.
o_seg  out  8  segment byte for the digit selected by o_sel; 8'hFF when blanked.
o_blank  out  1  high while segments are forced off.
o_frame  out  1  one-cycle pulse when o_sel wraps to 0.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset state (i_rst_n=0 at an edge):
  - prescaler count = 0; blank counter = 0.
  - o_sel = 0, o_seg = 8'hFF, o_blank = 1, o_frame = 0.
  - All 8 buffer entries = 8'hFF.
  - Reset mid-scan or mid-blank aborts immediately; no write is performed that cycle.
- Prescaler:
  - While i_en=1, the count increments each cycle.
  - When count >= i_div, a tick fires and the count clears to 0.
  - i_div=0 gives a tick every cycle.
  - i_div reduced below the current count ticks on the next cycle.
- i_en=0:
  - Prescaler clears to 0; o_sel holds.
  - o_blank=1 and o_seg=8'hFF from the next edge.
  - o_frame stays 0.
  - On re-enable, the current digit is shown after BLANK_CYC cycles, as after a tick.
- Tick at cycle t:
  - Next o_sel = 0 if o_sel >= i_last, else o_sel+1.
  - If it wraps, o_frame=1 at t+1 only.
  - An i_last lowered below the current o_sel wraps on the next tick.
- Blanking after a tick at t:
  - o_sel updates at t+1.
  - o_blank=1 and o_seg=8'hFF for cycles t+1..t+BLANK_CYC.
  - At t+BLANK_CYC+1, o_blank=0 and o_seg=buf[o_sel].
  - BLANK_CYC=0: o_seg=buf[new o_sel] and o_blank=0 at t+1.
  - If i_div+1 <= BLANK_CYC, the display remains blank permanently. This is legal and must not cause an error.
- Segment buffer:
  - i_wr=1 at edge t writes buf[i_waddr]=i_wdata.
  - If i_waddr equals the displayed o_sel and the block is not blanking, o_seg shows the new byte at t+2. One cycle of old data is permitted.
  - A write during a tick is valid; writes to any address are never dropped.
- Output registering: all outputs are registered. o_opt is a constant.
- Widths: the prescaler compare is unsigned, DIV_W bits. The blank counter is 8 bits. The select wraps modulo i_last+1.

Test Plan:
1. Reset, then i_en=1, i_div=3, i_last=7, BLANK_CYC=0 -> o_sel steps 0,1,...,7,0 every 4 cycles; o_frame pulses once per 32 cycles, aligned with o_sel=0.
2. Load buf[0..7]=8'h00..8'h07, i_div=9, BLANK_CYC=4 -> after each o_sel change, o_seg=FF with o_blank=1 for exactly 4 cycles, then o_seg=buf[o_sel] for 6 cycles.
3. i_last=2 mid-scan while o_sel=5 -> next tick gives o_sel=0 with o_frame=1; the sequence continues 0,1,2,0.
4. While digit 3 is displayed and not blanked, write i_waddr=3, i_wdata=8'hA5 -> o_seg=8'hA5 within 2 cycles; a write to address 6 leaves o_seg unchanged.
5. Deassert i_en mid-digit -> o_blank=1 and o_seg=FF next cycle, o_sel frozen; reassert -> blank for BLANK_CYC cycles, then the frozen digit's data is shown.
6. Pull i_rst_n low mid-blank with i_wr=1 -> next cycle o_sel=0, o_seg=FF, o_blank=1, o_frame=0; all buf entries read back as FF and the write is discarded.
